// File: rtl/ternary_pkg.sv
// rtl/ternary_pkg.sv - shared types for the balanced-ternary core sequencer
package ternary_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } seq_state_t;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t PC_INC = 2'b00;
  localparam pc_sel_t PC_BR  = 2'b01;
  localparam pc_sel_t PC_JMP = 2'b10;

endpackage

// File: rtl/btisa_seq_ctrl.sv
// rtl/btisa_seq_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with memory timeout
module btisa_seq_ctrl
  import ternary_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned RET_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_halt,
  input  logic             branch_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state_o,
  output logic             busy,
  output logic             halted,
  output logic             mem_err,
  output logic [RET_W-1:0] retired
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  seq_state_t        state, state_nxt;
  pc_sel_t           pc_sel_q, pc_sel_nxt;
  logic              mem_err_q, mem_err_nxt;
  logic              f_reg_write, f_mem_read, f_mem_write, f_branch, f_jump;
  logic [WAIT_W-1:0] wait_cnt;
  logic [RET_W-1:0]  retired_q;
  logic              waiting, acked, timeout;

  assign waiting = (state == FETCH) || (state == MEM);
  assign acked   = ((state == FETCH) && imem_ack) || ((state == MEM) && dmem_ack);
  // An ack in the final allowed cycle takes priority over the timeout.
  assign timeout = waiting && !acked && (MEM_TIMEOUT != 0) &&
                   ((32'(wait_cnt) + 32'd1) >= MEM_TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc_sel_q    <= PC_INC;
      mem_err_q   <= 1'b0;
      f_reg_write <= 1'b0;
      f_mem_read  <= 1'b0;
      f_mem_write <= 1'b0;
      f_branch    <= 1'b0;
      f_jump      <= 1'b0;
      wait_cnt    <= '0;
      retired_q   <= '0;
    end else begin
      state     <= state_nxt;
      pc_sel_q  <= pc_sel_nxt;
      mem_err_q <= mem_err_nxt;
      if (state == DECODE) begin
        f_reg_write <= dec_reg_write;
        f_mem_read  <= dec_mem_read;
        f_mem_write <= dec_mem_write;
        f_branch    <= dec_branch;
        f_jump      <= dec_jump;
      end
      if (state == WB) begin
        retired_q <= retired_q + RET_W'(1);
      end
      // Outside FETCH/MEM the counter sits at zero, so every entry starts fresh.
      if (waiting && !acked) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_sel_nxt  = pc_sel_q;
    mem_err_nxt = mem_err_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    pc_en       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = DECODE;
        end else if (timeout) begin
          state_nxt   = HALT;
          mem_err_nxt = 1'b1;
        end
      end
      DECODE: begin
        state_nxt = dec_halt ? HALT : EXEC;
      end
      EXEC: begin
        if (f_jump) pc_sel_nxt = PC_JMP;
        else if (f_branch && branch_taken) pc_sel_nxt = PC_BR;
        else pc_sel_nxt = PC_INC;
        state_nxt = (f_mem_read || f_mem_write) ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = f_mem_write;
        if (dmem_ack) begin
          state_nxt = WB;
        end else if (timeout) begin
          state_nxt   = HALT;
          mem_err_nxt = 1'b1;
        end
      end
      WB: begin
        rf_we     = f_reg_write;
        pc_en     = 1'b1;
        state_nxt = step_mode ? IDLE : FETCH;
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ir_load = imem_req & imem_ack;
  assign pc_sel  = pc_sel_q;
  assign state_o = state;
  assign busy    = (state != IDLE) && (state != HALT);
  assign halted  = (state == HALT);
  assign mem_err = mem_err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_btisa_seq_ctrl.sv
// tb/tb_btisa_seq_ctrl.sv - self-checking bench: per-instruction timeline model vs sequencer outputs
module tb_btisa_seq_ctrl;

  localparam int TO = 4;
  localparam int RW = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  logic clk = 1'b0;
  logic rst, start, step_mode, imem_ack, dmem_ack, branch_taken;
  logic dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_halt;
  logic imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, busy, halted, mem_err;
  logic [1:0] pc_sel;
  logic [2:0] state_o;
  logic [RW-1:0] retired;

  btisa_seq_ctrl #(.MEM_TIMEOUT(TO), .RET_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_branch(dec_branch), .dec_jump(dec_jump), .dec_halt(dec_halt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_en(pc_en), .pc_sel(pc_sel), .state_o(state_o), .busy(busy),
    .halted(halted), .mem_err(mem_err), .retired(retired)
  );

  initial forever #5 clk = ~clk;

  // One entry per clock: inputs to drive and the outputs the rules demand.
  typedef struct {
    bit rst, start, step, iack, dack, taken;
    bit [5:0] flags;
    bit [2:0] st;
    bit ireq, irl, dreq, dwe, rfwe, pcen, busy, halted, merr;
    bit [1:0] psel;
    int ret;
  } cyc_t;

  cyc_t tl[$];
  cyc_t cur;
  bit cur_v = 1'b0;
  int checks = 0, errors = 0;
  int pcen_cnt = 0, rfwe_cnt = 0, dreq_cnt = 0;
  bit m_idle;
  bit m_err;
  int m_ret;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic cyc_t base(input logic [2:0] st);
    cyc_t c;
    c.rst    = 1'b0;
    c.start  = (st == S_IDLE) ? 1'b0 : 1'($urandom_range(0, 1));
    c.step   = 1'($urandom_range(0, 1));
    c.iack   = (st == S_FETCH) ? 1'b0 : 1'($urandom_range(0, 1));
    c.dack   = (st == S_MEM) ? 1'b0 : 1'($urandom_range(0, 1));
    c.taken  = 1'($urandom_range(0, 1));
    c.flags  = (st == S_DEC) ? 6'd0 : 6'($urandom);
    c.st     = st;
    c.ireq   = (st == S_FETCH);
    c.irl    = 1'b0;
    c.dreq   = (st == S_MEM);
    c.dwe    = 1'b0;
    c.rfwe   = 1'b0;
    c.pcen   = 1'b0;
    c.psel   = 2'd0;
    c.busy   = (st != S_IDLE) && (st != S_HALT);
    c.halted = (st == S_HALT);
    c.merr   = m_err;
    c.ret    = m_ret;
    return c;
  endfunction

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) tl.push_back(base(S_IDLE));
  endtask

  task automatic add_halt();
    cyc_t c;
    for (int i = 0; i < 3; i++) begin
      c = base(S_HALT);
      if (i == 0) c.start = 1'b1;
      tl.push_back(c);
    end
  endtask

  task automatic add_reset_halt();
    cyc_t c;
    c = base(S_HALT);
    c.rst = 1'b1;
    tl.push_back(c);
    m_ret = 0; m_err = 1'b0; m_idle = 1'b1;
    tl.push_back(base(S_IDLE));
  endtask

  // nwait stall cycles then an ack, unless the stall reaches TO first.
  task automatic wait_phase(input logic [2:0] st, input int nwait, input bit we, output bit to);
    cyc_t c;
    to = 1'b0;
    for (int i = 0; i <= nwait; i++) begin
      c = base(st);
      c.dwe = we;
      if (i == nwait) begin
        if (st == S_FETCH) begin c.iack = 1'b1; c.irl = 1'b1; end
        else c.dack = 1'b1;
      end
      tl.push_back(c);
      if (i != nwait && i + 1 == TO) begin
        to = 1'b1; m_err = 1'b1;
        return;
      end
    end
  endtask

  task automatic add_instr(input bit rw, input bit mr, input bit mw, input bit br,
                           input bit jp, input bit hl, input bit tk, input int fw,
                           input int mwt, input bit step, input bit rst_mem);
    cyc_t c;
    bit to;
    bit [1:0] ps;
    if (m_idle) begin
      c = base(S_IDLE); c.start = 1'b1; tl.push_back(c); m_idle = 1'b0;
    end
    wait_phase(S_FETCH, fw, 1'b0, to);
    if (to) begin add_halt(); return; end
    c = base(S_DEC); c.flags = {hl, jp, br, mw, mr, rw}; tl.push_back(c);
    if (hl) begin add_halt(); return; end
    c = base(S_EXEC); c.taken = tk; tl.push_back(c);
    ps = jp ? 2'b10 : ((br && tk) ? 2'b01 : 2'b00);
    if (mr || mw) begin
      if (rst_mem) begin
        c = base(S_MEM); c.dwe = mw; c.rst = 1'b1; tl.push_back(c);
        m_ret = 0; m_err = 1'b0; m_idle = 1'b1;
        tl.push_back(base(S_IDLE));
        return;
      end
      wait_phase(S_MEM, mwt, mw, to);
      if (to) begin add_halt(); return; end
    end
    c = base(S_WB); c.step = step; c.rfwe = rw; c.pcen = 1'b1; c.psel = ps; tl.push_back(c);
    m_ret = (m_ret + 1) & ((1 << RW) - 1);
    m_idle = step;
  endtask

  task automatic run_tl();
    cyc_t c;
    while (tl.size() > 0) begin
      c = tl.pop_front();
      @(posedge clk); #1;
      rst = c.rst; start = c.start; step_mode = c.step;
      imem_ack = c.iack; dmem_ack = c.dack; branch_taken = c.taken;
      {dec_halt, dec_jump, dec_branch, dec_mem_write, dec_mem_read, dec_reg_write} = c.flags;
      cur = c; cur_v = 1'b1;
      @(negedge clk);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (cur_v) begin
      chk("state_o", state_o, cur.st);
      chk("imem_req", imem_req, cur.ireq);
      chk("ir_load", ir_load, cur.irl);
      chk("dmem_req", dmem_req, cur.dreq);
      if (cur.dreq) chk("dmem_we", dmem_we, cur.dwe);
      chk("rf_we", rf_we, cur.rfwe);
      chk("pc_en", pc_en, cur.pcen);
      if (cur.pcen) chk("pc_sel", pc_sel, cur.psel);
      chk("busy", busy, cur.busy);
      chk("halted", halted, cur.halted);
      chk("mem_err", mem_err, cur.merr);
      chk("retired", retired, cur.ret);
      pcen_cnt += int'(pc_en);
      rfwe_cnt += int'(rf_we);
      dreq_cnt += int'(dmem_req);
    end
  end

  initial begin
    int p0, r0, d0;
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    branch_taken = 1'b0; dec_reg_write = 1'b0; dec_mem_read = 1'b0; dec_mem_write = 1'b0;
    dec_branch = 1'b0; dec_jump = 1'b0; dec_halt = 1'b0;
    m_idle = 1'b1; m_err = 1'b0; m_ret = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_ir_load", ir_load, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_pc_sel", pc_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_retired", retired, 0);

    // Three back-to-back ALU ops with zero-wait fetch.
    add_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_idle(2);
    chk("add_timeline_len", tl.size(), 15);
    chk("add_model_retired", m_ret, 3);
    p0 = pcen_cnt; r0 = rfwe_cnt;
    run_tl();
    chk("add_retired", retired, 3);
    chk("add_pc_en_pulses", pcen_cnt - p0, 3);
    chk("add_rf_we_pulses", rfwe_cnt - r0, 3);

    // Load whose ack lands in the last cycle before timeout.
    add_instr(1, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    add_idle(1);
    chk("load_timeline_len", tl.size(), 10);
    d0 = dmem_req == 1'b1 ? dreq_cnt : dreq_cnt;
    run_tl();
    chk("load_dmem_req_cycles", dreq_cnt - d0, 4);
    chk("load_retired", retired, 4);
    chk("load_mem_err", mem_err, 0);

    // BEQ taken, BNE not taken, jump with fetch stall, NOP, load+store flags.
    add_instr(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add_instr(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    add_instr(0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
    add_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_instr(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    add_idle(1);
    p0 = pcen_cnt; r0 = rfwe_cnt;
    run_tl();
    chk("branch_pc_en_pulses", pcen_cnt - p0, 5);
    chk("branch_rf_we_pulses", rfwe_cnt - r0, 0);
    chk("branch_retired", retired, 9);

    // Reset while a store waits in MEM.
    add_instr(0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 1);
    run_tl();
    chk("midrst_dmem_req", dmem_req, 0);
    chk("midrst_retired", retired, 0);

    // Fetch ack exactly at the timeout boundary, then a halt opcode.
    add_instr(1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    add_instr(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    p0 = pcen_cnt;
    run_tl();
    chk("halt_halted", halted, 1);
    chk("halt_retired", retired, 1);
    chk("halt_pc_en_pulses", pcen_cnt - p0, 1);
    chk("halt_mem_err", mem_err, 0);
    add_reset_halt();
    run_tl();

    // Store that never gets an ack.
    add_instr(0, 0, 1, 0, 0, 0, 0, 0, 20, 0, 0);
    d0 = dreq_cnt;
    run_tl();
    chk("sto_dmem_req_cycles", dreq_cnt - d0, TO);
    chk("sto_mem_err", mem_err, 1);
    chk("sto_halted", halted, 1);
    chk("sto_dmem_req", dmem_req, 0);
    add_reset_halt();
    run_tl();
    chk("sto_rst_state", state_o, 0);
    chk("sto_rst_mem_err", mem_err, 0);

    // Fetch that never gets an ack.
    add_instr(1, 0, 0, 0, 0, 0, 0, 20, 0, 0, 0);
    run_tl();
    chk("fto_mem_err", mem_err, 1);
    add_reset_halt();
    run_tl();

    // Seventeen retirements wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++) add_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, (i == 16), 0);
    add_idle(1);
    chk("wrap_model_retired", m_ret, 1);
    run_tl();
    chk("wrap_retired", retired, 1);

    @(posedge clk); #1;
    cur_v = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
